// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation select encoding.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_ROR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } usr_mode_t;

endpackage

// File: rtl/dff_ar.sv
// Single storage bit: D flip-flop with enable and asynchronous active-low clear.
module dff_ar (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: shift/rotate/load/clear over per-bit flops, with a
// saturating count of shift operations since the last load, clear or reset.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] PI,
  input  logic             SIL,
  input  logic             SIR,
  output logic [WIDTH-1:0] PO,
  output logic             SOR,
  output logic             SOL,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] w_next;
  logic             w_isShift;
  logic             w_isZero;
  logic [CNT_W-1:0] r_count;

  always_comb begin
    w_next    = PO;
    w_isShift = 1'b0;
    w_isZero  = 1'b0;
    case (usr_mode_t'(mode))
      MODE_SHR: begin
        w_next    = {SIL, PO[WIDTH-1:1]};
        w_isShift = 1'b1;
      end
      MODE_SHL: begin
        w_next    = {PO[WIDTH-2:0], SIR};
        w_isShift = 1'b1;
      end
      MODE_ROR: begin
        w_next    = {PO[0], PO[WIDTH-1:1]};
        w_isShift = 1'b1;
      end
      MODE_ROL: begin
        w_next    = {PO[WIDTH-2:0], PO[WIDTH-1]};
        w_isShift = 1'b1;
      end
      MODE_LOAD: begin
        w_next   = PI;
        w_isZero = 1'b1;
      end
      MODE_CLEAR: begin
        w_next   = '0;
        w_isZero = 1'b1;
      end
      default: begin
        w_next = PO;
      end
    endcase
  end

  // The flops take the enable directly, so en low freezes every mode.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_ar u_dff (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_en    (en),
      .i_d     (w_next[i]),
      .o_q     (PO[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (en) begin
      if (w_isZero) begin
        r_count <= '0;
      end else if (w_isShift && (r_count != CNT_MAX)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign count = r_count;
  assign done  = (r_count == CNT_MAX);
  assign SOR   = PO[0];
  assign SOL   = PO[WIDTH-1];

endmodule
